// File: rtl/sparse_weight_csr_encoder_pkg.sv
// Shared sizes, derived widths and types for the sparse-weight CSR encoder.
// Optional magnitude pruning is enabled by defining WCSR_PRUNE_EN.
package wcsr_pkg;

  localparam int W_R     = 3;
  localparam int W_S     = 3;
  localparam int W_K     = 4;
  localparam int DATA_W  = 8;
  localparam int MAX_NNZ = 16;

  // Index width that stays at least 1 bit for degenerate (size 1) dimensions.
  function automatic int idx_bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int R_BW   = idx_bw(W_R);
  localparam int K_BW   = idx_bw(W_K);
  localparam int S_BW   = idx_bw(W_S);
  localparam int PTR_BW = $clog2(MAX_NNZ) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [R_BW-1:0]   r;
    logic [K_BW-1:0]   k;
  } entry_t;

endpackage

// File: rtl/sparse_weight_csr_encoder_scan_counter.sv
// Nested k (inner) / r / s (outer) scan position counters for one weight tile.
// Flags are combinational on the current position so the top can act on the beat in flight.
module wcsr_scan_counter
  import wcsr_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clear,
  input  logic            i_inc,
  output logic [S_BW-1:0] o_s,
  output logic [R_BW-1:0] o_r,
  output logic [K_BW-1:0] o_k,
  output logic            o_col_end,
  output logic            o_tile_end
);

  logic [S_BW-1:0] r_s;
  logic [R_BW-1:0] r_r;
  logic [K_BW-1:0] r_k;
  logic            w_k_end, w_r_end, w_s_end;

  assign w_k_end = (r_k == K_BW'(W_K - 1));
  assign w_r_end = (r_r == R_BW'(W_R - 1));
  assign w_s_end = (r_s == S_BW'(W_S - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s <= '0;
      r_r <= '0;
      r_k <= '0;
    end else if (i_clear) begin
      r_s <= '0;
      r_r <= '0;
      r_k <= '0;
    end else if (i_inc) begin
      if (w_k_end) begin
        r_k <= '0;
        if (w_r_end) begin
          r_r <= '0;
          r_s <= w_s_end ? '0 : r_s + 1'b1;
        end else begin
          r_r <= r_r + 1'b1;
        end
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign o_s        = r_s;
  assign o_r        = r_r;
  assign o_k        = r_k;
  assign o_col_end  = w_k_end & w_r_end;
  assign o_tile_end = w_k_end & w_r_end & w_s_end;

endmodule

// File: rtl/sparse_weight_csr_encoder.sv
// Dense weight tile -> column-pointer sparse form {val, r, k} plus per-column ptr array.
// Define WCSR_PRUNE_EN to add i_thresh and treat |i_data| <= i_thresh as zero.
module sparse_weight_csr_encoder
  import wcsr_pkg::*;
(
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic                               i_valid,
  input  logic [DATA_W-1:0]                  i_data,
`ifdef WCSR_PRUNE_EN
  input  logic [DATA_W-2:0]                  i_thresh,
`endif
  output logic                               o_ready,
  output logic [MAX_NNZ-1:0][DATA_W-1:0]     o_val,
  output logic [MAX_NNZ-1:0][R_BW-1:0]       o_r,
  output logic [MAX_NNZ-1:0][K_BW-1:0]       o_k,
  output logic [W_S:0][PTR_BW-1:0]           o_ptr,
  output logic [PTR_BW-1:0]                  o_nnz,
  output logic                               o_done,
  output logic                               o_overflow
);

  state_t                             r_state, w_state_nxt;
  logic                               r_ready;
  logic [MAX_NNZ-1:0][DATA_W-1:0]     r_val;
  logic [MAX_NNZ-1:0][R_BW-1:0]       r_r;
  logic [MAX_NNZ-1:0][K_BW-1:0]       r_k;
  logic [W_S:0][PTR_BW-1:0]           r_ptr;
  logic [PTR_BW-1:0]                  r_nnz;
  logic                               r_ovf;

  logic            w_start_acc, w_acc, w_nz, w_full, w_store, w_done, w_ready_nxt;
  logic [PTR_BW-1:0] w_nnz_nxt;
  logic [S_BW-1:0] w_s;
  logic [R_BW-1:0] w_r;
  logic [K_BW-1:0] w_k;
  logic            w_col_end, w_tile_end;
  entry_t          w_entry;

  assign w_start_acc = (r_state == S_IDLE) & i_start;
  assign w_acc       = i_valid & r_ready;

  wcsr_scan_counter u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_start_acc),
    .i_inc      (w_acc),
    .o_s        (w_s),
    .o_r        (w_r),
    .o_k        (w_k),
    .o_col_end  (w_col_end),
    .o_tile_end (w_tile_end)
  );

`ifdef WCSR_PRUNE_EN
  // Most-negative input has no positive twin; clamp its magnitude to the max positive.
  logic [DATA_W-1:0] w_mag;
  always_comb begin
    w_mag = i_data;
    if (i_data[DATA_W-1])
      w_mag = (i_data == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}}
                                                    : (~i_data + 1'b1);
  end
  assign w_nz = (w_mag > {1'b0, i_thresh});
`else
  assign w_nz = |i_data;
`endif

  assign w_full    = (r_nnz == PTR_BW'(MAX_NNZ));
  assign w_store   = w_acc & w_nz & ~w_full;
  assign w_nnz_nxt = r_nnz + PTR_BW'(w_store);
  assign w_entry   = '{val: i_data, r: w_r, k: w_k};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start)               w_state_nxt = S_SCAN;
      S_SCAN:  if (w_acc && w_tile_end)   w_state_nxt = S_DONE;
      S_DONE:                             w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; ready is registered so it tracks the state one-for-one
  always_comb begin
    w_done      = (r_state == S_DONE);
    w_ready_nxt = (w_state_nxt == S_SCAN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val <= '0;
      r_r   <= '0;
      r_k   <= '0;
      r_ptr <= '0;
      r_nnz <= '0;
      r_ovf <= 1'b0;
    end else if (w_start_acc) begin
      r_ptr <= '0;
      r_nnz <= '0;
      r_ovf <= 1'b0;
    end else if (w_acc) begin
      for (int j = 0; j < MAX_NNZ; j++) begin
        if (w_store && r_nnz == PTR_BW'(j)) begin
          r_val[j] <= w_entry.val;
          r_r[j]   <= w_entry.r;
          r_k[j]   <= w_entry.k;
        end
      end
      r_nnz <= w_nnz_nxt;
      if (w_nz && w_full) r_ovf <= 1'b1;
      // Column boundary uses the post-beat count so a column-final nonzero lands in its own column.
      if (w_col_end) begin
        for (int c = 0; c < W_S; c++)
          if (w_s == S_BW'(c)) r_ptr[c+1] <= w_nnz_nxt;
      end
    end
  end

  assign o_ready    = r_ready;
  assign o_val      = r_val;
  assign o_r        = r_r;
  assign o_k        = r_k;
  assign o_ptr      = r_ptr;
  assign o_nnz      = r_nnz;
  assign o_done     = w_done;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_sparse_weight_csr_encoder.sv
// Scoreboard bench for sparse_weight_csr_encoder; prune scenario runs when WCSR_PRUNE_EN is defined.
module tb_sparse_weight_csr_encoder;
  import wcsr_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           start = 1'b0;
  logic                           valid = 1'b0;
  logic [DATA_W-1:0]              data = '0;
`ifdef WCSR_PRUNE_EN
  logic [DATA_W-2:0]              thresh = '0;
`endif
  logic                           ready;
  logic [MAX_NNZ-1:0][DATA_W-1:0] o_val;
  logic [MAX_NNZ-1:0][R_BW-1:0]   o_r;
  logic [MAX_NNZ-1:0][K_BW-1:0]   o_k;
  logic [W_S:0][PTR_BW-1:0]       o_ptr;
  logic [PTR_BW-1:0]              o_nnz;
  logic                           done;
  logic                           ovf;

  sparse_weight_csr_encoder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_valid    (valid),
    .i_data     (data),
`ifdef WCSR_PRUNE_EN
    .i_thresh   (thresh),
`endif
    .o_ready    (ready),
    .o_val      (o_val),
    .o_r        (o_r),
    .o_k        (o_k),
    .o_ptr      (o_ptr),
    .o_nnz      (o_nnz),
    .o_done     (done),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  localparam int BEATS = W_S * W_R * W_K;

  int          checks = 0;
  int          failures = 0;
  logic [DATA_W-1:0] tile [BEATS];
  entry_t      sb_q [$];
  int          exp_nnz;
  logic        exp_ovf;
  int          exp_ptr [W_S+1];

  function automatic bit is_nz(input logic [DATA_W-1:0] d);
`ifdef WCSR_PRUNE_EN
    int m;
    m = $signed(d);
    if (m < 0) m = -m;
    if (m > 127) m = 127;
    return m > int'(thresh);
`else
    return d != 0;
`endif
  endfunction

  task automatic clear_tile();
    for (int i = 0; i < BEATS; i++) tile[i] = '0;
  endtask

  task automatic set_identity();
    clear_tile();
    tile[0]  = 8'sd5;
    tile[23] = -8'sd7;
    tile[28] = 8'sd1;
  endtask

  task automatic model_beat(input int b, input logic [DATA_W-1:0] d);
    entry_t e;
    if (is_nz(d)) begin
      if (exp_nnz < MAX_NNZ) begin
        e.val = d;
        e.r   = R_BW'((b / W_K) % W_R);
        e.k   = K_BW'(b % W_K);
        sb_q.push_back(e);
        exp_nnz++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (b % (W_R * W_K) == W_R * W_K - 1) exp_ptr[b / (W_R * W_K) + 1] = exp_nnz;
  endtask

  // Drives one tile (optional random gaps / stray start), then compares everything against the scoreboard.
  task automatic run_tile(input string nm, input int gap_pct, input bit mid_start);
    int b, cyc;
    bit mid_done;
    sb_q.delete();
    exp_nnz = 0;
    exp_ovf = 1'b0;
    for (int j = 0; j <= W_S; j++) exp_ptr[j] = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    b = 0; cyc = 0; mid_done = 0;
    while (b < BEATS && cyc < 4000) begin
      valid = ($urandom_range(99) >= gap_pct);
      data  = valid ? tile[b] : DATA_W'($urandom);
      start = (mid_start && b == 10 && !mid_done);
      if (start) mid_done = 1;
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL %s ready_in_scan beat=%0d got=%b exp=1", nm, b, ready);
      end
      if (valid && b == BEATS - 1) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL %s done_early got=%b exp=0", nm, done);
        end
      end
      if (valid) model_beat(b, tile[b]);
      @(posedge clk); #1;
      cyc++;
      if (valid) b++;
    end
    valid = 1'b0;
    start = 1'b0;
    checks++;
    if (b != BEATS) begin
      failures++;
      $display("FAIL %s timeout beats=%0d exp=%0d", nm, b, BEATS);
    end
    checks++;
    if (done !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse got done=%b ready=%b exp done=1 ready=0", nm, done, ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width got=%b exp=0", nm, done);
    end
    checks++;
    if (o_nnz !== PTR_BW'(exp_nnz)) begin
      failures++;
      $display("FAIL %s nnz got=%0d exp=%0d", nm, o_nnz, exp_nnz);
    end
    checks++;
    if (ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s overflow got=%b exp=%b", nm, ovf, exp_ovf);
    end
    for (int j = 0; j <= W_S; j++) begin
      checks++;
      if (o_ptr[j] !== PTR_BW'(exp_ptr[j])) begin
        failures++;
        $display("FAIL %s ptr[%0d] got=%0d exp=%0d", nm, j, o_ptr[j], exp_ptr[j]);
      end
    end
    for (int i = 0; sb_q.size() > 0; i++) begin
      entry_t e;
      e = sb_q.pop_front();
      checks++;
      if ({o_val[i], o_r[i], o_k[i]} !== e) begin
        failures++;
        $display("FAIL %s entry[%0d] got val=%0d r=%0d k=%0d exp val=%0d r=%0d k=%0d",
                 nm, i, $signed(o_val[i]), o_r[i], o_k[i], $signed(e.val), e.r, e.k);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || done !== 1'b0 || o_nnz !== '0 || ovf !== 1'b0 || o_ptr !== '0) begin
      failures++;
      $display("FAIL reset got ready=%b done=%b nnz=%0d ovf=%b ptr=%h exp all 0",
               ready, done, o_nnz, ovf, o_ptr);
    end
  endtask

  task automatic test_identity();
    set_identity();
    run_tile("identity", 0, 0);
    // Literal results for this tile, independent of the scoreboard model
    checks++;
    if (o_nnz !== 5'd3 || o_ptr[1] !== 5'd1 || o_ptr[2] !== 5'd2 || o_ptr[3] !== 5'd3 ||
        o_val[1] !== 8'hF9 || o_r[1] !== 2'd2 || o_k[1] !== 2'd3) begin
      failures++;
      $display("FAIL identity_literal got nnz=%0d ptr=%h val1=%h r1=%0d k1=%0d exp nnz=3 ptr=0,1,2,3 val1=f9 r1=2 k1=3",
               o_nnz, o_ptr, o_val[1], o_r[1], o_k[1]);
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < BEATS; i++) tile[i] = 8'd1;
    run_tile("all_ones", 0, 0);
    checks++;
    if (ovf !== 1'b1 || o_ptr[1] !== 5'd12 || o_ptr[2] !== 5'd16 || o_ptr[3] !== 5'd16) begin
      failures++;
      $display("FAIL all_ones_literal got ovf=%b ptr=%h exp ovf=1 ptr=0,12,16,16", ovf, o_ptr);
    end
  endtask

  task automatic test_all_zero();
    clear_tile();
    run_tile("all_zero", 0, 0);
  endtask

  task automatic test_back_to_back();
    set_identity();
    run_tile("gaps_identity", 40, 1);
    for (int i = 0; i < BEATS; i++) tile[i] = (i % 5 == 0) ? DATA_W'(i + 100) : '0;
    run_tile("gaps_sparse", 60, 1);
  endtask

  task automatic test_reset_mid_scan();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    valid = 1'b1;
    data  = 8'd1;
    repeat (20) @(posedge clk);
    #1 valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || o_nnz !== '0 || ovf !== 1'b0 || o_ptr !== '0 || o_val !== '0) begin
      failures++;
      $display("FAIL reset_mid got ready=%b nnz=%0d ovf=%b ptr=%h exp all 0", ready, o_nnz, ovf, o_ptr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    set_identity();
    run_tile("after_reset", 0, 0);
  endtask

`ifdef WCSR_PRUNE_EN
  task automatic test_prune();
    clear_tile();
    tile[0] = 8'sd3;
    tile[1] = -8'sd2;
    tile[2] = 8'sd2;
    tile[3] = -8'sd3;
    tile[4] = 8'h80;
    thresh = 7'd2;
    run_tile("prune", 0, 0);
    checks++;
    if (o_nnz !== 5'd3 || o_ptr[1] !== 5'd3 || o_val[0] !== 8'd3 || o_val[1] !== 8'hFD || o_val[2] !== 8'h80) begin
      failures++;
      $display("FAIL prune_literal got nnz=%0d ptr1=%0d vals=%h,%h,%h exp 3 3 03,fd,80",
               o_nnz, o_ptr[1], o_val[0], o_val[1], o_val[2]);
    end
    thresh = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_all_ones();
    test_all_zero();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef WCSR_PRUNE_EN
    test_prune();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
